// File: rtl/mem_pipe_arbiter.sv
// Round-robin arbiter sharing one load/store pipe between NUM_REQ select ports,
// credit-limited against free LSU queue entries, with a one-cycle output slot.
module mem_pipe_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PKT_W   = 128,
    parameter int CREDITS = 8,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     laneActive_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*PKT_W-1:0] req_pkt_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     credit_ret_i,
    output logic                     out_valid_o,
    output logic [PKT_W-1:0]         out_pkt_o,
    output logic [1:0]               out_src_o,
    output logic [CNT_W-1:0]         credits_o,
    output logic [1:0]               state_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BLOCKED = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_ptr;
    logic [CNT_W-1:0]   r_credits;
    logic               r_out_valid;
    logic [PKT_W-1:0]   r_out_pkt;
    logic [1:0]         r_out_src;
    logic               r_err;

    logic               w_found;
    logic [1:0]         w_win;
    logic               w_grant;
    logic [PKT_W-1:0]   w_win_pkt;
    logic [1:0]         w_ptr_inc;
    logic               w_refund;
    logic [CNT_W:0]     w_cred_sum;
    logic [CNT_W-1:0]   w_cred_next;
    logic               w_overflow;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_found && req_valid_i[idx]) begin
                w_found = 1'b1;
                w_win   = 2'(idx);
            end
        end
    end

    assign w_grant = !reset && (r_state != ST_FLUSH) && !flush_i && laneActive_i &&
                     (r_credits != '0) && w_found;
    assign w_win_pkt = req_pkt_i[int'(w_win)*PKT_W +: PKT_W];
    assign w_ptr_inc = (w_win == 2'(NUM_REQ-1)) ? 2'd0 : w_win + 2'd1;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = w_grant && (w_win == 2'(gi));
        end
    endgenerate

    // A presented packet that gets flushed never reaches the LSU, so its credit comes back.
    assign w_refund   = flush_i && r_out_valid;
    assign w_cred_sum = {1'b0, r_credits} - {{CNT_W{1'b0}}, w_grant}
                      + {{CNT_W{1'b0}}, credit_ret_i} + {{CNT_W{1'b0}}, w_refund};
    assign w_overflow  = w_cred_sum > (CNT_W+1)'(CREDITS);
    assign w_cred_next = w_overflow ? CNT_W'(CREDITS) : w_cred_sum[CNT_W-1:0];

    always_comb begin
        w_state_next = ST_GRANT;
        if (flush_i)
            w_state_next = ST_FLUSH;
        else if (r_state == ST_FLUSH)
            w_state_next = ST_IDLE;
        else if (!(|req_valid_i) || !laneActive_i)
            w_state_next = ST_IDLE;
        else if (w_cred_next == '0)
            w_state_next = ST_BLOCKED;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= 2'd0;
            r_credits   <= CNT_W'(CREDITS);
            r_out_valid <= 1'b0;
            r_out_pkt   <= '0;
            r_out_src   <= 2'd0;
            r_err       <= 1'b0;
        end else begin
            r_credits   <= w_cred_next;
            r_out_valid <= w_grant;
            r_out_pkt   <= w_grant ? w_win_pkt : '0;
            r_out_src   <= w_grant ? w_win : 2'd0;
            if (w_grant)
                r_ptr <= w_ptr_inc;
            if (w_overflow)
                r_err <= 1'b1;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_pkt_o   = r_out_pkt;
    assign out_src_o   = r_out_src;
    assign credits_o   = r_credits;
    assign state_o     = r_state;
    assign err_o       = r_err;

endmodule

// File: tb/tb_mem_pipe_arbiter.sv
// Directed bench for mem_pipe_arbiter: fairness, credit exhaustion, flush refund,
// overflow, lane gating and mid-operation reset.
module tb_mem_pipe_arbiter;

    localparam int NUM_REQ = 2;
    localparam int PKT_W   = 128;
    localparam int CREDITS = 8;
    localparam int CNT_W   = 4;

    logic                     clk;
    logic                     reset;
    logic                     flush_i;
    logic                     laneActive_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*PKT_W-1:0] req_pkt_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic                     credit_ret_i;
    logic                     out_valid_o;
    logic [PKT_W-1:0]         out_pkt_o;
    logic [1:0]               out_src_o;
    logic [CNT_W-1:0]         credits_o;
    logic [1:0]               state_o;
    logic                     err_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [PKT_W-1:0] p0;
    logic [PKT_W-1:0] p1;

    mem_pipe_arbiter #(
        .NUM_REQ(NUM_REQ), .PKT_W(PKT_W), .CREDITS(CREDITS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .laneActive_i(laneActive_i),
        .req_valid_i(req_valid_i), .req_pkt_i(req_pkt_i), .req_ready_o(req_ready_o),
        .credit_ret_i(credit_ret_i), .out_valid_o(out_valid_o), .out_pkt_o(out_pkt_o),
        .out_src_o(out_src_o), .credits_o(credits_o), .state_o(state_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        p0 = {4{32'hA5A50000}};
        p1 = {4{32'h5A5A1111}};
        reset = 1'b1; flush_i = 1'b0; laneActive_i = 1'b1;
        req_valid_i = '0; credit_ret_i = 1'b0;
        req_pkt_i = {p1, p0};
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_valid",   128'(out_valid_o), 128'd0);
        chk("rst_pkt",     128'(out_pkt_o),   128'd0);
        chk("rst_src",     128'(out_src_o),   128'd0);
        chk("rst_credits", 128'(credits_o),   128'd8);
        chk("rst_state",   128'(state_o),     128'd0);
        chk("rst_err",     128'(err_o),       128'd0);
        chk("rst_ready",   128'(req_ready_o), 128'd0);

        // Fairness: both valid, a credit returned every cycle.
        req_valid_i = 2'b11; credit_ret_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fair_ready", 128'(req_ready_o), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
            if (i > 0) begin
                chk("fair_ovalid", 128'(out_valid_o), 128'd1);
                chk("fair_src",    128'(out_src_o),   128'((i - 1) % 2));
                chk("fair_pkt",    128'(out_pkt_o),   ((i - 1) % 2 == 0) ? p0 : p1);
                chk("fair_cred",   128'(credits_o),   128'd8);
            end
            tick();
        end
        req_valid_i = 2'b00; credit_ret_i = 1'b0;
        tick();

        // Credit exhaustion with requester 0 alone.
        req_valid_i = 2'b01;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("exh_ready", 128'(req_ready_o), 128'd1);
            tick();
        end
        chk("exh_ready0", 128'(req_ready_o), 128'd0);
        chk("exh_state",  128'(state_o),     128'd2);
        chk("exh_cred",   128'(credits_o),   128'd0);
        credit_ret_i = 1'b1;
        #1;
        chk("exh_ret_noready", 128'(req_ready_o), 128'd0);
        tick();
        credit_ret_i = 1'b0;
        #1;
        chk("exh_regrant", 128'(req_ready_o), 128'd1);
        chk("exh_state_g", 128'(state_o),     128'd1);
        tick();
        chk("exh_ready_again0", 128'(req_ready_o), 128'd0);
        chk("exh_cred0",        128'(credits_o),   128'd0);

        // Refill to 8, then one extra return to provoke overflow.
        req_valid_i = 2'b00; credit_ret_i = 1'b1;
        repeat (8) tick();
        chk("refill_cred", 128'(credits_o), 128'd8);
        chk("pre_ovf_err", 128'(err_o),     128'd0);
        tick();
        credit_ret_i = 1'b0;
        chk("ovf_cred", 128'(credits_o), 128'd8);
        chk("ovf_err",  128'(err_o),     128'd1);
        tick();
        chk("ovf_sticky", 128'(err_o), 128'd1);

        // Flush refund: grant in t, flush in t+1.
        req_valid_i = 2'b01;
        #1;
        chk("fl_grant", 128'(req_ready_o), 128'd1);
        tick();
        req_valid_i = 2'b00; flush_i = 1'b1;
        chk("fl_ovalid_t1", 128'(out_valid_o), 128'd1);
        chk("fl_cred_t1",   128'(credits_o),   128'd7);
        tick();
        flush_i = 1'b0; req_valid_i = 2'b01;
        #1;
        chk("fl_ovalid_t2", 128'(out_valid_o), 128'd0);
        chk("fl_cred_t2",   128'(credits_o),   128'd8);
        chk("fl_state_t2",  128'(state_o),     128'd3);
        chk("fl_noready",   128'(req_ready_o), 128'd0);
        tick();
        chk("fl_ready_t3", 128'(req_ready_o), 128'd1);
        tick();
        chk("fl_cred_t4", 128'(credits_o), 128'd7);

        // Drain to one credit, then grant and return together.
        repeat (6) tick();
        chk("sim_cred_pre", 128'(credits_o), 128'd1);
        credit_ret_i = 1'b1;
        #1;
        chk("sim_ready", 128'(req_ready_o), 128'd1);
        tick();
        credit_ret_i = 1'b0; req_valid_i = 2'b00;
        chk("sim_cred",   128'(credits_o),   128'd1);
        chk("sim_ovalid", 128'(out_valid_o), 128'd1);

        // Lane gating.
        laneActive_i = 1'b0; req_valid_i = 2'b11;
        #1;
        chk("lane_ready", 128'(req_ready_o), 128'd0);
        tick();
        chk("lane_state",  128'(state_o),     128'd0);
        chk("lane_ovalid", 128'(out_valid_o), 128'd0);
        chk("lane_ready2", 128'(req_ready_o), 128'd0);

        // Reset with a packet in flight (winner 0 leaves pointer at 1).
        laneActive_i = 1'b1; req_valid_i = 2'b01;
        tick();
        chk("rmid_ovalid", 128'(out_valid_o), 128'd1);
        chk("rmid_src",    128'(out_src_o),   128'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; req_valid_i = 2'b11;
        #1;
        chk("rmid_ovalid0", 128'(out_valid_o), 128'd0);
        chk("rmid_cred",    128'(credits_o),   128'd8);
        chk("rmid_err",     128'(err_o),       128'd0);
        chk("rmid_state",   128'(state_o),     128'd0);
        chk("rmid_ptr",     128'(req_ready_o), 128'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
